// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode and execute for the RISC datapath.
// Define CPU_CTRL_HALT_EN to decode opcode 111 into a HALT state left only by reset.
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);
    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b11;
    localparam logic [1:0] MNONE      = 2'b00;
    localparam logic [1:0] MREAD      = 2'b01;
    localparam logic [1:0] MWRITE     = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [4:0] I_MOVI = 5'b110_10;
    localparam logic [4:0] I_MOVR = 5'b110_00;
    localparam logic [4:0] I_MVN  = 5'b101_11;
    localparam logic [4:0] I_ADD  = 5'b101_00;
    localparam logic [4:0] I_CMP  = 5'b101_01;
    localparam logic [4:0] I_AND  = 5'b101_10;
    localparam logic [4:0] I_LDR  = 5'b011_00;
    localparam logic [4:0] I_STR  = 5'b100_00;

    // ALU_M is the ALU step of MOV reg, split out so asel stays a pure function of state.
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM,
        S_GETA, S_GETB, S_ALU, S_ALU_M, S_WRD, S_CMP,
        S_ADDR, S_LADR, S_MRD, S_WBM, S_GRD, S_STC, S_SWR
`ifdef CPU_CTRL_HALT_EN
        , S_HALT
`endif
    } state_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [4:0] ir_q, ir_d;
    ctrl_t      out_q, out_d;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        c.mem_cmd = MNONE;
        case (s)
            S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
            S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
            S_UPC:   c.load_pc = 1'b1;
            S_WIMM:  begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
            S_GETA:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            S_GETB:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            S_ALU:   c.loadc = 1'b1;
            S_ALU_M: begin c.loadc = 1'b1; c.asel = 1'b1; end
            S_WRD:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
            S_CMP:   c.loads = 1'b1;
            S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LADR:  c.load_addr = 1'b1;
            S_MRD:   c.mem_cmd = MREAD;
            S_WBM:   begin
                c.mem_cmd = MREAD; c.nsel = NSEL_RD; c.vsel = VSEL_MDATA; c.write = 1'b1;
            end
            S_GRD:   begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_STC:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_SWR:   c.mem_cmd = MWRITE;
`ifdef CPU_CTRL_HALT_EN
            S_HALT:  c.halted = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                ir_d = {opcode, op};
                casez ({opcode, op})
                    I_MOVI:                state_d = S_WIMM;
                    I_MOVR, I_MVN:         state_d = S_GETB;
                    I_ADD, I_AND, I_CMP:   state_d = S_GETA;
                    I_LDR, I_STR:          state_d = S_GETA;
`ifdef CPU_CTRL_HALT_EN
                    5'b111_??:             state_d = S_HALT;
`endif
                    default:               state_d = S_IF1;
                endcase
            end
            S_WIMM: state_d = S_IF1;
            S_GETA: state_d = (ir_q == I_LDR || ir_q == I_STR) ? S_ADDR : S_GETB;
            S_GETB: begin
                if (ir_q == I_MOVR)     state_d = S_ALU_M;
                else if (ir_q == I_CMP) state_d = S_CMP;
                else                    state_d = S_ALU;
            end
            S_ALU, S_ALU_M: state_d = S_WRD;
            S_WRD:  state_d = S_IF1;
            S_CMP:  state_d = S_IF1;
            S_ADDR: state_d = S_LADR;
            S_LADR: state_d = (ir_q == I_STR) ? S_GRD : S_MRD;
            S_MRD:  state_d = S_WBM;
            S_WBM:  state_d = S_IF1;
            S_GRD:  state_d = S_STC;
            S_STC:  state_d = S_SWR;
            S_SWR:  state_d = S_IF1;
`ifdef CPU_CTRL_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_RST;
        endcase
        out_d = decode(state_d);
    end

    // Outputs are registered from the next-state decode, so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            ir_q    <= '0;
            out_q   <= decode(S_RST);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
        end
    end

    assign nsel      = out_q.nsel;
    assign vsel      = out_q.vsel;
    assign write     = out_q.write;
    assign loada     = out_q.loada;
    assign loadb     = out_q.loadb;
    assign loadc     = out_q.loadc;
    assign loads     = out_q.loads;
    assign asel      = out_q.asel;
    assign bsel      = out_q.bsel;
    assign load_ir   = out_q.load_ir;
    assign load_pc   = out_q.load_pc;
    assign reset_pc  = out_q.reset_pc;
    assign addr_sel  = out_q.addr_sel;
    assign load_addr = out_q.load_addr;
    assign mem_cmd   = out_q.mem_cmd;
    assign halted    = out_q.halted;
endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: walks each instruction class state by state.
// Outputs are packed into one vector and compared against hand-built per-state constants.
module tb_cpu_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel, mem_cmd;
    logic write, loada, loadb, loadc, loads, asel, bsel;
    logic load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;

    int checks = 0;
    int errors = 0;

    cpu_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .load_ir(load_ir), .load_pc(load_pc),
        .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
        .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

    // Field masks in the obs layout.
    localparam logic [19:0] N_RN = 20'h20000, N_RD = 20'h40000, N_RM = 20'h80000;
    localparam logic [19:0] V_IMM = 20'h08000, V_C = 20'h18000;
    localparam logic [19:0] WR = 20'h04000, LA = 20'h02000, LB = 20'h01000, LC = 20'h00800;
    localparam logic [19:0] LS = 20'h00400, AS = 20'h00200, BS = 20'h00100, LIR = 20'h00080;
    localparam logic [19:0] LPC = 20'h00040, RPC = 20'h00020, AD = 20'h00010, LAD = 20'h00008;
    localparam logic [19:0] MR = 20'h00002, MW = 20'h00004, HLT = 20'h00001;

    localparam logic [19:0] E_RST  = RPC | LPC;
    localparam logic [19:0] E_IF1  = AD | MR;
    localparam logic [19:0] E_IF2  = AD | MR | LIR;
    localparam logic [19:0] E_UPC  = LPC;
    localparam logic [19:0] E_DEC  = 20'h00000;
    localparam logic [19:0] E_WIMM = N_RN | V_IMM | WR;
    localparam logic [19:0] E_GETA = N_RN | LA;
    localparam logic [19:0] E_GETB = N_RM | LB;
    localparam logic [19:0] E_ALU  = LC;
    localparam logic [19:0] E_ALUM = LC | AS;
    localparam logic [19:0] E_WRD  = N_RD | V_C | WR;
    localparam logic [19:0] E_CMP  = LS;
    localparam logic [19:0] E_ADDR = BS | LC;
    localparam logic [19:0] E_LADR = LAD;
    localparam logic [19:0] E_MRD  = MR;
    localparam logic [19:0] E_WBM  = MR | N_RD | WR;
    localparam logic [19:0] E_GRD  = N_RD | LB;
    localparam logic [19:0] E_STC  = AS | LC;
    localparam logic [19:0] E_SWR  = MW;
    localparam logic [19:0] E_HALT = HLT;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] exp [2];
        reset = 1'b1; opcode = 3'b000; op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_RST) begin
                errors++; $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, E_RST);
            end
        end
        reset = 1'b0;
        exp = '{E_IF1, E_IF2};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL reset_release step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_mov_imm();
        logic [19:0] exp [6];
        do_reset();
        opcode = 3'b110; op = 2'b10;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_WIMM, E_IF1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL mov_imm step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [19:0] exp [9];
        do_reset();
        opcode = 3'b101; op = 2'b00;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_GETB, E_ALU, E_WRD, E_IF1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL add step %0d: got %h expected %h", i, obs, exp[i]);
            end
            // Opcode moves after decode; the instruction in flight must not notice.
            if (i == 4) begin opcode = 3'b000; op = 2'b00; end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp [16];
        do_reset();
        opcode = 3'b101; op = 2'b10;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_GETB, E_ALU, E_WRD,
                E_IF1, E_IF2, E_UPC, E_DEC, E_GETB, E_ALU, E_WRD, E_IF1};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL and_mvn step %0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i == 7) begin opcode = 3'b101; op = 2'b11; end
        end
    endtask

    task automatic test_mov_reg();
        logic [19:0] exp [8];
        do_reset();
        opcode = 3'b110; op = 2'b00;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETB, E_ALUM, E_WRD, E_IF1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL mov_reg step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [19:0] exp [8];
        do_reset();
        opcode = 3'b101; op = 2'b01;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_GETB, E_CMP, E_IF1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL cmp step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_ldr();
        logic [19:0] exp [10];
        do_reset();
        opcode = 3'b011; op = 2'b00;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_ADDR, E_LADR, E_MRD, E_WBM, E_IF1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL ldr step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_str();
        logic [19:0] exp [11];
        do_reset();
        opcode = 3'b100; op = 2'b00;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_ADDR, E_LADR, E_GRD, E_STC, E_SWR, E_IF1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL str step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_str_reset();
        logic [19:0] exp [11];
        do_reset();
        opcode = 3'b100; op = 2'b00;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_GETA, E_ADDR, E_LADR, E_GRD, E_RST, E_IF1, E_IF2};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL str_reset step %0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i == 7) reset = 1'b1;
            if (i == 8) begin reset = 1'b0; opcode = 3'b000; end
        end
    endtask

    task automatic test_illegal();
        logic [19:0] exp [6];
        do_reset();
        opcode = 3'b001; op = 2'b01;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC, E_IF1, E_IF2};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL illegal step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_op111();
        logic [19:0] exp [4];
        do_reset();
        opcode = 3'b111; op = 2'b10;
        exp = '{E_IF1, E_IF2, E_UPC, E_DEC};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL op111 step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
`ifdef CPU_CTRL_HALT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_HALT) begin
                errors++; $display("FAIL halt cycle %0d: got %h expected %h", i, obs, E_HALT);
            end
            if (i == 2) opcode = 3'b110;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_RST) begin
            errors++; $display("FAIL halt_exit: got %h expected %h", obs, E_RST);
        end
        reset = 1'b0;
`else
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL op111_nohalt step %0d: got %h expected %h", i, obs, exp[i]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_back_to_back();
        test_mov_reg();
        test_cmp();
        test_ldr();
        test_str();
        test_str_reset();
        test_illegal();
        test_op111();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
